register_file: RTL
==================

# register_file

Parametrised multi-entry register file: generalises the single enabled 4-bit register to DEPTH entries of WIDTH bits. One write port, two combinational read ports with optional write-to-read bypass, and a background clear sweep that zeroes one entry per cycle. Holds FPU operand/result values in the core datapath and feeds both operand buses of the execution stage.

## Interface
- WIDTH, 64, bits per entry
- DEPTH, 8, number of entries (≥2; need not be a power of two)
- BYPASS, 1, 1 = read port returns writeData on a same-cycle write to the same address; 0 = returns stored value
- ADDR_W, $clog2(DEPTH), derived localparam, not overridable
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- writeEnable  in  1  request to write writeData to writeAddr
- writeAddr  in  ADDR_W  write address
- writeData  in  WIDTH  write data
- writeAccepted  out  1  combinational: writeEnable & !busy & writeAddr < DEPTH
- readAddrA, readAddrB  in  ADDR_W  read addresses
- readDataA, readDataB  out  WIDTH  combinational read data
- clearReq  in  1  start a clear sweep (sampled in IDLE only)
- busy  out  1  registered, 1 while the sweep runs
- dirty  out  DEPTH  registered, bit i = entry i written since last reset/clear of that entry

## Operation
- Reset (reset_n=0, immediate, no clock needed): all entries 0, dirty 0, busy 0, state IDLE, sweep pointer 0.
- Write: at rising edge with writeAccepted=1, entry[writeAddr] <= writeData, dirty[writeAddr] <= 1. writeAddr ≥ DEPTH: write dropped, no state change. Writes while busy=1 dropped (writeAccepted=0).
- Read: readDataX = entry[readAddrX]; readAddrX ≥ DEPTH returns 0. If BYPASS=1 and writeAccepted=1 and writeAddr==readAddrX, readDataX = writeData. Both ports may address the same entry.
- Sweep FSM, states IDLE, SWEEP:
  - IDLE: clearReq=1 at an edge → SWEEP, pointer <= 0, busy <= 1.
  - SWEEP: each edge, entry[pointer] <= 0, dirty[pointer] <= 0; pointer == DEPTH-1 → IDLE, busy <= 0, pointer <= 0; else pointer++.
  - clearReq while SWEEP ignored (no restart, no queueing).
- Simultaneous clearReq and writeEnable in IDLE: write is accepted at that edge (busy still 0); sweep then clears that entry like any other.
- Reads during SWEEP allowed: return current storage (already-swept entries read 0). Bypass inactive during SWEEP (no accepted writes).
- Reset mid-sweep: sweep aborts, state IDLE, all entries and dirty 0.

## Timing
- Write-to-read latency: 1 cycle via storage; 0 cycles via bypass when BYPASS=1.
- clearReq sampled at edge k: busy=1 after edge k; entry i zeroed at edge k+1+i; busy=0 after edge k+DEPTH. Sweep occupies exactly DEPTH cycles; first write accepted at edge k+DEPTH+1.
- writeAccepted and read outputs are combinational from inputs and current state; no internal combinational loop (bypass mux on write inputs only).

## Structure
- Package register_pkg: sweep state enum (SW_IDLE, SW_SWEEP); shared by future register blocks.
- Sub-module register_n (WIDTH parameter): enabled register with asynchronous active-low clear, same q = en ? d : q behaviour as the existing enabled registers; instantiated DEPTH times. Enable per entry = (accepted write to i) | (sweep at i); d = sweep at i ? 0 : writeData.
- Sweep FSM, pointer, dirty vector and read/bypass muxes live in register_file.

## Test plan
- Reset: drive reset_n=0 mid-run with entries loaded → all readData 0, dirty 0, busy 0 without a clock edge.
- Write/read: write 0xDEAD_BEEF to addr 3, next cycle readAddrA=3 → 0xDEAD_BEEF, dirty=8'b0000_1000; readAddrB=5 → 0.
- Bypass: BYPASS=1, writeEnable with addr 2 data 0x55, readAddrA=readAddrB=2 same cycle → both 0x55; BYPASS=0 build → old value (0).
- Sweep: fill all 8 entries, pulse clearReq at edge k → busy high for 8 cycles, entry i reads 0 after edge k+1+i, dirty clears bit by bit; write during busy → writeAccepted=0, storage unchanged.
- Edge cases: clearReq+write addr 7 same edge in IDLE → write lands, cleared at edge k+8; clearReq during SWEEP → no extension; DEPTH=6 build, writeAddr=7 → dropped, readAddr=7 → 0.
- Reset mid-sweep at pointer 4 → immediate IDLE, busy 0, all entries 0; next clearReq restarts from 0.

Source files
------------

// File: rtl/register_pkg.sv
// register_pkg
// Shared definitions for the register blocks of the FPU datapath.
// Contents:
//   sweep_state_t - state encoding of the background clear sweep
//                   (SW_IDLE: normal operation, SW_SWEEP: zeroing entries)
package register_pkg;

    typedef enum logic [0:0] {
        SW_IDLE  = 1'b0,
        SW_SWEEP = 1'b1
    } sweep_state_t;

endpackage

// File: rtl/register_n.sv
// register_n
// WIDTH-bit enabled register with asynchronous active-low clear.
// Holds its value unless en is high at a rising clock edge.
// Ports:
//   clk      in  1      rising-edge clock
//   reset_n  in  1      asynchronous active-low clear (q -> 0)
//   en       in  1      load enable
//   d        in  WIDTH  next value when enabled
//   q        out WIDTH  stored value
module register_n #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file.sv
// register_file
// DEPTH x WIDTH register file holding FPU operands/results. One write port,
// two combinational read ports (optional write-to-read bypass) and a
// background clear sweep that zeroes one entry per cycle while busy.
// Ports:
//   clk            in  1       rising-edge clock
//   reset_n        in  1       asynchronous active-low reset
//   writeEnable    in  1       write request
//   writeAddr      in  ADDR_W  write address
//   writeData      in  WIDTH   write data
//   writeAccepted  out 1       write will land at the next edge
//   readAddrA/B    in  ADDR_W  read addresses
//   readDataA/B    out WIDTH   combinational read data
//   clearReq       in  1       start a clear sweep (only honoured when idle)
//   busy           out 1       sweep in progress
//   dirty          out DEPTH   bit i set when entry i written since last clear
module register_file
    import register_pkg::*;
#(
    parameter  int WIDTH  = 64,
    parameter  int DEPTH  = 8,
    parameter  bit BYPASS = 1'b1,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              writeEnable,
    input  logic [ADDR_W-1:0] writeAddr,
    input  logic [WIDTH-1:0]  writeData,
    output logic              writeAccepted,
    input  logic [ADDR_W-1:0] readAddrA,
    input  logic [ADDR_W-1:0] readAddrB,
    output logic [WIDTH-1:0]  readDataA,
    output logic [WIDTH-1:0]  readDataB,
    input  logic              clearReq,
    output logic              busy,
    output logic [DEPTH-1:0]  dirty
);

    sweep_state_t      state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic [DEPTH-1:0]  dirty_q, dirty_d;
    logic [WIDTH-1:0]  entry_q [DEPTH];
    logic              write_ok;
    logic              sweeping;

    assign sweeping      = (state_q == SW_SWEEP);
    // Addresses beyond DEPTH exist when DEPTH is not a power of two; such
    // writes are silently dropped.
    assign write_ok      = writeEnable && !busy_q && (int'(writeAddr) < DEPTH);
    assign writeAccepted = write_ok;
    assign busy          = busy_q;
    assign dirty         = dirty_q;

    // Writes are only possible in SW_IDLE because busy blocks them during a
    // sweep, so the dirty set and clear never collide on the same edge.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        dirty_d = dirty_q;
        case (state_q)
            SW_IDLE: begin
                if (write_ok) begin
                    dirty_d[writeAddr] = 1'b1;
                end
                if (clearReq) begin
                    state_d = SW_SWEEP;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            SW_SWEEP: begin
                dirty_d[ptr_q] = 1'b0;
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = SW_IDLE;
                    ptr_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = SW_IDLE;
                ptr_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SW_IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            dirty_q <= dirty_d;
        end
    end

    // Each entry loads either the write data or zero from the sweep; the two
    // sources are mutually exclusive because writes are blocked while busy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic hit_write;
        logic hit_sweep;

        assign hit_write = write_ok && (writeAddr == ADDR_W'(i));
        assign hit_sweep = sweeping && (ptr_q == ADDR_W'(i));

        register_n #(
            .WIDTH(WIDTH)
        ) u_reg (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (hit_write | hit_sweep),
            .d       (hit_sweep ? '0 : writeData),
            .q       (entry_q[i])
        );
    end

    // Bypass depends only on write-port inputs and registered state, so it
    // cannot form a combinational loop through the read ports.
    always_comb begin
        readDataA = '0;
        if (int'(readAddrA) < DEPTH) begin
            readDataA = entry_q[readAddrA];
        end
        if (BYPASS && write_ok && (writeAddr == readAddrA)) begin
            readDataA = writeData;
        end
    end

    always_comb begin
        readDataB = '0;
        if (int'(readAddrB) < DEPTH) begin
            readDataB = entry_q[readAddrB];
        end
        if (BYPASS && write_ok && (writeAddr == readAddrB)) begin
            readDataB = writeData;
        end
    end

endmodule
